// File: rtl/jtframe_z80_pkg.sv
// Shared definitions for the Z80 interrupt controller.
//  - FSM state encodings (2-bit)
//  - IM0 RST opcode base and spurious-acknowledge vectors
//  - helpers that build the vector byte for a given mode/index
package jtframe_z80_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam logic [7:0] IM0_RST_BASE = 8'hC7;
  localparam logic [7:0] IM0_SPUR     = 8'hFF;

  // IM2 table base with bit 0 forced low; also the IM2 spurious vector
  function automatic logic [7:0] im2_base(input logic [7:0] vbase);
    return {vbase[7:1], 1'b0};
  endfunction

  // Vector for an acknowledged source. IM2 addition wraps at 8 bits.
  function automatic logic [7:0] z80_vec(input int mode, input logic [7:0] vbase,
                                         input logic [2:0] idx);
    if (mode == 0) return IM0_RST_BASE | {2'b00, idx, 3'b000};
    else           return im2_base(vbase) + {4'b0000, idx, 1'b0};
  endfunction

  function automatic logic [7:0] spur_vec(input int mode, input logic [7:0] vbase);
    if (mode == 0) return IM0_SPUR;
    else           return im2_base(vbase);
  endfunction

endpackage

// File: rtl/jtframe_z80_intprio.sv
// Combinational priority encoder, lowest index wins.
//  req : request vector
//  any : at least one request set
//  idx : index of the lowest set request (0 when none)
module jtframe_z80_intprio #(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            any,
  output logic [2:0]      idx
);

  always_comb begin
    any = |req;
    idx = 3'd0;
    // scan downward so the lowest set index is the last one written
    for (int i = NSRC-1; i >= 0; i--)
      if (req[i]) idx = 3'(i);
  end

endmodule

// File: rtl/jtframe_z80_intctl.sv
// Z80 maskable-interrupt responder.
// Latches rising edges on irq, drives int_n while an enabled source is
// pending, and answers the CPU acknowledge cycle (M1 & IORQ low) with a
// vector byte on vec_dout/vec_oe, retiring the acknowledged source.
//  rst      : synchronous reset, active high
//  clk      : system clock
//  irq      : edge-triggered requests, bit 0 highest priority
//  mask     : 1 = source may assert int_n
//  clr      : one-clk software clear of pending bits
//  m1_n     : CPU M1
//  iorq_n   : CPU IORQ
//  int_n    : CPU INT pin (registered)
//  vec_dout : vector / RST opcode byte
//  vec_oe   : vec_dout must be muxed onto the CPU data bus
//  pending  : latched request status
module jtframe_z80_intctl
  import jtframe_z80_pkg::*;
#(
  parameter int         NSRC  = 4,
  parameter int         MODE  = 2,
  parameter logic [7:0] VBASE = 8'hE0
) (
  input  logic            rst,
  input  logic            clk,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] mask,
  input  logic [NSRC-1:0] clr,
  input  logic            m1_n,
  input  logic            iorq_n,
  output logic            int_n,
  output logic [7:0]      vec_dout,
  output logic            vec_oe,
  output logic [NSRC-1:0] pending
);

  logic [NSRC-1:0] irq_l, edges, retire_bits;
  logic [1:0]      state, state_nx;
  logic            any, ack, retire, spur;
  logic [2:0]      win;

  assign ack   = !m1_n && !iorq_n;
  assign edges = irq & ~irq_l;

  jtframe_z80_intprio #(.NSRC(NSRC)) u_prio (
    .req (pending & mask),
    .any (any),
    .idx (win)
  );

  always_comb begin
    retire_bits = '0;
    for (int i = 0; i < NSRC; i++)
      retire_bits[i] = retire && (win == 3'(i));
  end

  // A CPU acknowledge always gets an answer: a real vector when an
  // enabled source is pending, otherwise the spurious one.
  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    spur     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ack) begin
          state_nx = ST_ACK;
          spur     = 1'b1;
        end else if (any) begin
          state_nx = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (ack) begin
          state_nx = ST_ACK;
          retire   = any;
          spur     = !any;
        end else if (!any) begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (iorq_n) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_l    <= irq;  // a line already high at release is not an edge
      pending  <= '0;
      state    <= ST_IDLE;
      int_n    <= 1'b1;
      vec_oe   <= 1'b0;
      vec_dout <= 8'h00;
    end else begin
      irq_l   <= irq;
      // a new edge wins over any clear in the same clk
      pending <= edges | (pending & ~(clr | retire_bits));
      state   <= state_nx;
      int_n   <= state_nx != ST_ASSERT;
      vec_oe  <= state_nx == ST_ACK;
      if (retire) vec_dout <= z80_vec(MODE, VBASE, win);
      else if (spur) vec_dout <= spur_vec(MODE, VBASE);
    end
  end

endmodule

// File: tb/tb_jtframe_z80_intctl.sv
module tb_jtframe_z80_intctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq, mask, clr;
  logic       m1_n, iorq_n;
  logic       int_n2, vec_oe2, int_n0, vec_oe0;
  logic [7:0] vec2, vec0;
  logic [3:0] pend2, pend0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtframe_z80_intctl #(.NSRC(4), .MODE(2), .VBASE(8'hE0)) u_im2 (
    .rst(rst), .clk(clk), .irq(irq), .mask(mask), .clr(clr),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n2), .vec_dout(vec2),
    .vec_oe(vec_oe2), .pending(pend2)
  );

  jtframe_z80_intctl #(.NSRC(4), .MODE(0), .VBASE(8'hE0)) u_im0 (
    .rst(rst), .clk(clk), .irq(irq), .mask(mask), .clr(clr),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_n(int_n0), .vec_dout(vec0),
    .vec_oe(vec_oe0), .pending(pend0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; irq = '0; mask = 4'hF; clr = '0; m1_n = 1'b1; iorq_n = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic ack_on();  m1_n = 1'b0; iorq_n = 1'b0; endtask
  task automatic ack_off(); m1_n = 1'b1; iorq_n = 1'b1; endtask

  initial begin
    do_reset();
    chk("rst_int_n", int_n2, 1);
    chk("rst_vec_oe", vec_oe2, 0);
    chk("rst_vec", vec2, 8'h00);
    chk("rst_pending", pend2, 0);

    // single source, IM2
    irq = 4'b0100;
    tick();
    chk("t1_pend_set", pend2, 4'b0100);
    chk("t1_int_n_N", int_n2, 1);
    tick();
    chk("t1_int_n_N1", int_n2, 0);
    irq = '0;
    ack_on();
    tick();
    chk("t1_vec", vec2, 8'hE4);
    chk("t1_vec_oe", vec_oe2, 1);
    chk("t1_int_n_ack", int_n2, 1);
    chk("t1_pend_clr", pend2, 0);
    ack_off();
    tick();
    chk("t1_vec_oe_rel", vec_oe2, 0);
    chk("t1_vec_hold", vec2, 8'hE4);

    // two simultaneous sources, IM0
    do_reset();
    irq = 4'b1010;
    tick();
    chk("t2_pend", pend0, 4'b1010);
    tick();
    chk("t2_int_n", int_n0, 0);
    irq = '0;
    ack_on();
    tick();
    chk("t2_vec1", vec0, 8'hCF);
    chk("t2_pend1", pend0, 4'b1000);
    ack_off();
    tick();
    chk("t2_int_n_R", int_n0, 1);
    chk("t2_vec_oe_R", vec_oe0, 0);
    tick();
    chk("t2_int_n_R1", int_n0, 0);
    ack_on();
    tick();
    chk("t2_vec2", vec0, 8'hDF);
    chk("t2_pend2", pend0, 4'b0000);
    ack_off();
    tick();

    // masked source
    do_reset();
    mask = 4'b1110;
    irq = 4'b0001;
    tick();
    irq = '0;
    chk("t3_pend", pend2, 4'b0001);
    tick(); tick();
    chk("t3_masked_int_n", int_n2, 1);
    mask = 4'hF;
    tick(); tick();
    chk("t3_unmask_int_n", int_n2, 0);

    // software clear while asserting
    do_reset();
    irq = 4'b0010;
    tick();
    irq = '0;
    tick();
    chk("t4_int_n", int_n2, 0);
    clr = 4'b0010;
    tick();
    clr = '0;
    chk("t4_pend_clr", pend2, 0);
    tick();
    chk("t4_int_n_rel", int_n2, 1);

    // spurious ack in IDLE with a masked source pending
    do_reset();
    mask = 4'h0;
    irq = 4'b0100;
    tick();
    irq = '0;
    tick();
    ack_on();
    tick();
    chk("t5_spur_im2", vec2, 8'hE0);
    chk("t5_spur_im0", vec0, 8'hFF);
    chk("t5_spur_oe", vec_oe2, 1);
    chk("t5_spur_pend", pend2, 4'b0100);
    ack_off();
    tick();
    mask = 4'hF;

    // edge on the source being acknowledged
    do_reset();
    irq = 4'b0010;
    tick();
    irq = '0;
    tick();
    chk("t5b_int_n", int_n2, 0);
    ack_on();
    irq = 4'b0010;
    tick();
    chk("t5b_vec", vec2, 8'hE2);
    chk("t5b_pend_kept", pend2, 4'b0010);
    ack_off();
    irq = '0;
    tick(); tick();
    chk("t5b_reassert", int_n2, 0);

    // reset during ACK with requests held high
    do_reset();
    irq = 4'b0001;
    tick();
    irq = '0;
    tick();
    ack_on();
    tick();
    chk("t6_in_ack", vec_oe2, 1);
    irq = 4'hF;
    rst = 1'b1;
    tick();
    chk("t6_rst_oe", vec_oe2, 0);
    chk("t6_rst_int_n", int_n2, 1);
    chk("t6_rst_vec", vec2, 8'h00);
    chk("t6_rst_pend", pend2, 0);
    rst = 1'b0;
    ack_off();
    tick(); tick();
    chk("t6_post_pend", pend2, 0);
    chk("t6_post_int_n", int_n2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
